// File: rtl/desp_sched.sv
// Dispenser scheduler: round-robin grant of one valve among three request channels,
// with pause on supply loss, timed settle, request-drop abort and alarm fault handling.
module desp_sched #(
  parameter int DISP_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int PAUSE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       al_in,
  input  logic       c_in,
  output logic [2:0] gnt,
  output logic       valve,
  output logic       busy,
  output logic       done,
  output logic       abort,
  output logic [1:0] done_id,
  output logic       fault
);

  localparam logic [15:0] DISP_LAST   = 16'(DISP_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] PAUSE_LAST  = 16'(PAUSE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DISPENSE = 3'd1,
    PAUSE    = 3'd2,
    SETTLE   = 3'd3,
    FAULT    = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] dcnt, dcnt_nxt;   // valve-open cycles served; survives PAUSE
  logic [15:0] tcnt, tcnt_nxt;   // per-state timer for PAUSE and SETTLE
  logic [1:0]  ptr, ptr_nxt;     // first channel of the next round-robin search
  logic [1:0]  cur, cur_nxt;
  logic        abt, abt_nxt;
  logic [2:0]  gnt_nxt;
  logic        valve_nxt, busy_nxt, done_nxt, abort_nxt, fault_nxt;
  logic [1:0]  done_id_nxt;
  logic [1:0]  pick;

  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [2:0] rot;
    logic [1:0] k;
    logic [2:0] s;
    unique case (p)
      2'd1:    rot = {r[0], r[2], r[1]};
      2'd2:    rot = {r[1], r[0], r[2]};
      default: rot = r;
    endcase
    if (rot[0])      k = 2'd0;
    else if (rot[1]) k = 2'd1;
    else             k = 2'd2;
    s = {1'b0, p} + {1'b0, k};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    unique case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  assign pick = rr_pick(req, ptr);

  always_comb begin
    state_nxt   = state;
    dcnt_nxt    = dcnt;
    tcnt_nxt    = tcnt;
    ptr_nxt     = ptr;
    cur_nxt     = cur;
    abt_nxt     = abt;
    done_nxt    = 1'b0;
    abort_nxt   = 1'b0;
    done_id_nxt = done_id;

    unique case (state)
      IDLE: begin
        if (al_in) begin
          state_nxt = FAULT;
        end else if ((req != 3'b000) && c_in) begin
          state_nxt = DISPENSE;
          cur_nxt   = pick;
          ptr_nxt   = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
          dcnt_nxt  = '0;
          abt_nxt   = 1'b0;
        end
      end
      DISPENSE: begin
        // Request drop outranks supply loss so a simultaneous drop aborts instead of pausing.
        if (al_in) begin
          state_nxt = FAULT;
        end else if (!req[cur]) begin
          state_nxt = SETTLE;
          abt_nxt   = 1'b1;
        end else if (!c_in) begin
          state_nxt = PAUSE;
        end else if (dcnt == DISP_LAST) begin
          state_nxt = SETTLE;
        end else begin
          dcnt_nxt = dcnt + 16'd1;
        end
      end
      PAUSE: begin
        if (al_in) begin
          state_nxt = FAULT;
        end else if (!req[cur]) begin
          state_nxt = SETTLE;
          abt_nxt   = 1'b1;
        end else if (c_in) begin
          state_nxt = DISPENSE;
        end else if (tcnt == PAUSE_LAST) begin
          state_nxt = FAULT;
        end else begin
          tcnt_nxt = tcnt + 16'd1;
        end
      end
      SETTLE: begin
        if (al_in) begin
          state_nxt = FAULT;
        end else if (tcnt == SETTLE_LAST) begin
          state_nxt   = IDLE;
          done_id_nxt = cur;
          done_nxt    = !abt;
          abort_nxt   = abt;
        end else begin
          tcnt_nxt = tcnt + 16'd1;
        end
      end
      FAULT: begin
        if (!al_in && c_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) tcnt_nxt = '0;

    busy_nxt  = (state_nxt != IDLE);
    valve_nxt = (state_nxt == DISPENSE);
    fault_nxt = (state_nxt == FAULT);
    gnt_nxt   = ((state_nxt == DISPENSE) || (state_nxt == PAUSE) || (state_nxt == SETTLE))
                ? onehot(cur_nxt) : 3'b000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      dcnt    <= '0;
      tcnt    <= '0;
      ptr     <= '0;
      cur     <= '0;
      abt     <= 1'b0;
      gnt     <= '0;
      valve   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      abort   <= 1'b0;
      done_id <= '0;
      fault   <= 1'b0;
    end else begin
      state   <= state_nxt;
      dcnt    <= dcnt_nxt;
      tcnt    <= tcnt_nxt;
      ptr     <= ptr_nxt;
      cur     <= cur_nxt;
      abt     <= abt_nxt;
      gnt     <= gnt_nxt;
      valve   <= valve_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      abort   <= abort_nxt;
      done_id <= done_id_nxt;
      fault   <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_desp_sched.sv
// Scoreboard bench for desp_sched: a phase-level reference model predicts the outputs
// after every clock edge; a negedge monitor pops and compares.
module tb_desp_sched;
  localparam int DISP   = 4;
  localparam int SETTLE = 2;
  localparam int PTO    = 8;

  localparam int P_IDLE   = 0;
  localparam int P_DISP   = 1;
  localparam int P_PAUSE  = 2;
  localparam int P_SETTLE = 3;
  localparam int P_FAULT  = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req   = 3'b000;
  logic       al_in = 1'b0;
  logic       c_in  = 1'b0;
  logic [2:0] gnt;
  logic       valve, busy, done, abort, fault;
  logic [1:0] done_id;

  desp_sched #(
    .DISP_CYCLES  (DISP),
    .SETTLE_CYCLES(SETTLE),
    .PAUSE_TIMEOUT(PTO)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .al_in  (al_in),
    .c_in   (c_in),
    .gnt    (gnt),
    .valve  (valve),
    .busy   (busy),
    .done   (done),
    .abort  (abort),
    .done_id(done_id),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  logic [9:0] expq[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which phase we are in, which channel is served, how much is left.
  int         ph, ch, last, rem, sleft, pz;
  bit         aborted, pd, pa;
  logic [1:0] did;
  logic [2:0] eg;

  function automatic int pick_rr(input logic [2:0] r, input int lst);
    int c;
    for (int k = 1; k <= 3; k++) begin
      c = (lst + k) % 3;
      if (((int'(r) >> c) & 1) != 0) return c;
    end
    return 0;
  endfunction

  function automatic bit has_req(input logic [2:0] r, input int c);
    return ((int'(r) >> c) & 1) != 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph = P_IDLE; last = 2; ch = 0; rem = 0; sleft = 0; pz = 0;
      aborted = 1'b0; did = 2'd0;
      expq.delete();
      expq.push_back(10'b0);
    end else begin
      pd = 1'b0; pa = 1'b0;
      case (ph)
        P_IDLE: begin
          if (al_in) ph = P_FAULT;
          else if (req != 3'b000 && c_in) begin
            ch = pick_rr(req, last); last = ch; rem = DISP; aborted = 1'b0; ph = P_DISP;
          end
        end
        P_DISP: begin
          if (al_in) ph = P_FAULT;
          else if (!has_req(req, ch)) begin ph = P_SETTLE; sleft = SETTLE; aborted = 1'b1; end
          else if (!c_in) begin ph = P_PAUSE; pz = 0; end
          else begin
            rem = rem - 1;
            if (rem == 0) begin ph = P_SETTLE; sleft = SETTLE; end
          end
        end
        P_PAUSE: begin
          if (al_in) ph = P_FAULT;
          else if (!has_req(req, ch)) begin ph = P_SETTLE; sleft = SETTLE; aborted = 1'b1; end
          else if (c_in) ph = P_DISP;
          else begin
            pz = pz + 1;
            if (pz == PTO) ph = P_FAULT;
          end
        end
        P_SETTLE: begin
          if (al_in) ph = P_FAULT;
          else begin
            sleft = sleft - 1;
            if (sleft == 0) begin
              ph = P_IDLE; did = 2'(ch);
              if (aborted) pa = 1'b1; else pd = 1'b1;
            end
          end
        end
        default: begin
          if (!al_in && c_in) ph = P_IDLE;
        end
      endcase
      eg = (ph == P_DISP || ph == P_PAUSE || ph == P_SETTLE) ? 3'(1 << ch) : 3'b000;
      expq.push_back({eg, ph == P_DISP, ph != P_IDLE, pd, pa, did, ph == P_FAULT});
    end
  end

  logic [9:0] act, ex;
  always @(negedge clk) begin
    act = {gnt, valve, busy, done, abort, done_id, fault};
    n_cmp++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL q_empty t=%0t: no expected entry, dut=%b", $time, act);
    end else begin
      ex = expq.pop_front();
      if (act !== ex) begin
        n_bad++;
        $display("FAIL outputs t=%0t {gnt,valve,busy,done,abort,done_id,fault} got=%b want=%b",
                 $time, act, ex);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int lowrun = 0;

  initial begin
    #1 reset = 1'b0;
    tick(3);
    reset = 1'b1;

    // single request, full service
    req = 3'b001; c_in = 1'b1; al_in = 1'b0;
    tick(8);
    req = 3'b000;
    tick(8);

    // all channels requesting: round-robin rotation
    req = 3'b111;
    tick(28);
    req = 3'b000;
    tick(8);

    // supply loss until pause timeout, then recovery
    req = 3'b001;
    tick(3);
    c_in = 1'b0;
    tick(12);
    c_in = 1'b1;
    tick(2);
    req = 3'b000;
    tick(8);

    // pause then resume with frozen count
    req = 3'b100;
    tick(2);
    c_in = 1'b0;
    tick(3);
    c_in = 1'b1;
    tick(8);
    req = 3'b000;
    tick(6);

    // request drop at dispense cycle 2
    req = 3'b010;
    tick(2);
    req = 3'b000;
    tick(6);

    // simultaneous request drop and supply loss
    req = 3'b001;
    tick(2);
    req = 3'b000; c_in = 1'b0;
    tick(1);
    c_in = 1'b1;
    tick(6);

    // alarm mid-dispense
    req = 3'b001;
    tick(2);
    al_in = 1'b1;
    tick(2);
    al_in = 1'b0;
    tick(3);
    req = 3'b000;
    tick(8);

    // asynchronous reset mid-dispense
    req = 3'b010;
    tick(2);
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (valve !== 1'b0 || gnt !== 3'b000 || busy !== 1'b0 || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset got valve=%b gnt=%b busy=%b fault=%b want 0 000 0 0",
               valve, gnt, busy, fault);
    end
    tick(2);
    reset = 1'b1;
    tick(10);
    req = 3'b000;
    tick(6);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) req = 3'($urandom_range(7));
      if (lowrun > 0) begin
        c_in = 1'b0;
        lowrun--;
      end else if ($urandom_range(99) == 0) begin
        lowrun = int'($urandom_range(12, 6));
        c_in = 1'b0;
      end else begin
        c_in = ($urandom_range(9) != 0);
      end
      al_in = ($urandom_range(79) == 0);
      tick(1);
    end

    req = 3'b000; al_in = 1'b0; c_in = 1'b1;
    tick(3);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/desp_sched.md
DESP_SCHED -- requirements
Module: desp_sched

Interface
REQ-001 Parameter: DISP_CYCLES, 16, valve-open duration per grant in clk cycles (1..65535).
REQ-002 Parameter: SETTLE_CYCLES, 4, post-dispense settle duration in clk cycles (1..65535).
REQ-003 Parameter: PAUSE_TIMEOUT, 64, maximum consecutive paused cycles before fault (1..65535).
REQ-004 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: req  in  3  level request per channel 0..2.
REQ-007 Port: al_in  in  1  dispenser alarm status (1 = alarm).
REQ-008 Port: c_in  in  1  dispenser ready/supply status (1 = ready).
REQ-009 Port: gnt  out  3  one-hot grant; held for the whole service.
REQ-010 Port: valve  out  1  valve drive (1 = open).
REQ-011 Port: busy  out  1  high in every state except IDLE.
REQ-012 Port: done  out  1  one-cycle pulse on completed service.
REQ-013 Port: abort  out  1  one-cycle pulse on service cut short by request drop.
REQ-014 Port: done_id  out  2  channel of the last done/abort pulse; holds between pulses.
REQ-015 Port: fault  out  1  high while in FAULT.

Function
REQ-016 The block SHALL be a registered FSM with states IDLE, DISPENSE, PAUSE, SETTLE and FAULT; all outputs are registered.
REQ-017 IDLE: al_in=1 -> FAULT; else if req!=0 and c_in=1 -> DISPENSE with gnt set to the round-robin winner and valve=1 from that edge; otherwise stay.
REQ-018 Round-robin: search starts at the channel after the last granted one; after reset the search order is 0,1,2.
REQ-019 DISPENSE: valve=1 for exactly DISP_CYCLES cycles counted only while c_in=1, then SETTLE with valve=0.
REQ-020 DISPENSE with c_in=0 and al_in=0: -> PAUSE, valve=0, count frozen; PAUSE returns to DISPENSE with valve=1 when c_in=1, resuming the frozen count.
REQ-021 PAUSE: after PAUSE_TIMEOUT consecutive cycles with c_in=0 -> FAULT.
REQ-022 DISPENSE or PAUSE with req[granted]=0: -> SETTLE with valve=0 and an abort flag recorded.
REQ-023 SETTLE: valve=0, gnt held, SETTLE_CYCLES cycles; on the exit edge -> IDLE, gnt=0, done_id=granted channel, done=1 (or abort=1 if flagged, never both).
REQ-024 IDLE SHALL last at least one cycle after SETTLE; no grant on the done/abort edge.
REQ-025 al_in=1 in any non-FAULT state SHALL take priority: next edge -> FAULT, valve=0, gnt=0, fault=1, no done/abort pulse.
REQ-026 FAULT: exit to IDLE on the first edge sampling al_in=0 and c_in=1; the round-robin pointer is unchanged by the fault.
REQ-027 Simultaneous req drop and c_in=0 in DISPENSE SHALL follow REQ-022 (abort beats pause).
REQ-028 Counters SHALL be 16 bits and SHALL never wrap; the counter reloads on every state entry.
REQ-029 valve=1 SHALL imply exactly one gnt bit set and state DISPENSE.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, gnt=0, valve=0, busy=0, done=0, abort=0, done_id=0, fault=0 and the round-robin pointer to channel 0, independent of clk and including mid-DISPENSE.

Verification
REQ-031 DISP_CYCLES=4, SETTLE_CYCLES=2, req=001, c_in=1 sampled at edge 1 -> gnt=001 and valve=1 after edges 1-4; valve=0 after edges 5-6; done=1 and done_id=0 after edge 7 for one cycle.
REQ-032 req=111 held, c_in=1 -> grant order 001, 010, 100, 001, with a single IDLE cycle between services.
REQ-033 c_in=0 during DISPENSE for PAUSE_TIMEOUT=8 cycles -> valve=0 on the first paused cycle, fault=1 after the 8th, gnt=000; al_in=0 and c_in=1 -> IDLE.
REQ-034 req drops at dispense cycle 2 -> valve=0 next edge, SETTLE runs in full, abort=1 and done=0 on exit.
REQ-035 al_in=1 mid-DISPENSE -> FAULT next edge with no pulse; reset=0 mid-DISPENSE between clock edges -> valve=0 and gnt=000 without a clock edge.
